// File: rtl/m_seq_checker.sv
// ---------------------------------------------------------------------------
// m_seq_checker
//   Receive-side checker for a 4-stage m-sequence (period 15,
//   s(n+4) = s(n+3) ^ s(n)). It first self-synchronises by loading the
//   incoming bits into a history register. Once enough consecutive bits are
//   predicted correctly, it free-runs a local LFSR and counts mismatches
//   for BER measurement. Too many errors inside one window drop lock.
//
// Ports
//   clk        in   rising-edge clock
//   res        in   synchronous reset, active-high
//   din_vld    in   din carries a valid bit this cycle
//   din        in   serial PRBS bit, oldest first
//   clr_cnt    in   synchronous clear of err_cnt / bit_cnt
//   locked     out  1 while in LOCKED state
//   err_pulse  out  one-cycle pulse: last checked bit mismatched
//   lock_lost  out  one-cycle pulse: LOCKED -> SEARCH
//   err_cnt    out  mismatches while LOCKED (saturating)
//   bit_cnt    out  bits checked while LOCKED (saturating)
// ---------------------------------------------------------------------------
module m_seq_checker #(
    parameter int LOCK_CNT = 8,
    parameter int LOS_WIN  = 15,
    parameter int LOS_THR  = 4,
    parameter int CNT_W    = 16
) (
    input  logic             clk,
    input  logic             res,
    input  logic             din_vld,
    input  logic             din,
    input  logic             clr_cnt,
    output logic             locked,
    output logic             err_pulse,
    output logic             lock_lost,
    output logic [CNT_W-1:0] err_cnt,
    output logic [CNT_W-1:0] bit_cnt
);

    typedef enum logic {
        SEARCH = 1'b0,
        LOCKED = 1'b1
    } state_t;

    localparam logic [7:0]       MATCH_LAST = 8'(LOCK_CNT - 1);
    localparam logic [7:0]       WIN_LAST   = 8'(LOS_WIN - 1);
    localparam logic [8:0]       THR        = 9'(LOS_THR);
    localparam logic [CNT_W-1:0] CNT_MAX    = '1;

    state_t           state_q, state_d;
    logic [3:0]       h_q, h_d;
    logic [2:0]       fill_q, fill_d;
    logic [7:0]       match_q, match_d;
    logic [7:0]       win_cnt_q, win_cnt_d;
    logic [7:0]       win_err_q, win_err_d;
    logic             err_pulse_q, err_pulse_d;
    logic             lock_lost_q, lock_lost_d;
    logic [CNT_W-1:0] err_cnt_q, err_cnt_d;
    logic [CNT_W-1:0] bit_cnt_q, bit_cnt_d;

    logic             pred;
    logic             err;
    logic [8:0]       win_err_sum;

    // h[3] is the newest bit, h[0] the oldest: h[3]^h[0] predicts the next one.
    assign pred        = h_q[3] ^ h_q[0];
    assign err         = din ^ pred;
    assign win_err_sum = {1'b0, win_err_q} + {8'd0, err};

    always_comb begin
        state_d     = state_q;
        h_d         = h_q;
        fill_d      = fill_q;
        match_d     = match_q;
        win_cnt_d   = win_cnt_q;
        win_err_d   = win_err_q;
        err_pulse_d = 1'b0;
        lock_lost_d = 1'b0;
        err_cnt_d   = err_cnt_q;
        bit_cnt_d   = bit_cnt_q;

        if (din_vld) begin
            case (state_q)
                SEARCH: begin
                    h_d = {din, h_q[3:1]};
                    if (fill_q < 3'd4) begin
                        fill_d = fill_q + 3'd1;
                    end else if ((din == pred) && (h_q != 4'b0000)) begin
                        // All-zero history can never be a match, so a dead
                        // line (constant 0) never reaches lock.
                        if (match_q == MATCH_LAST) begin
                            state_d   = LOCKED;
                            match_d   = 8'd0;
                            win_cnt_d = 8'd0;
                            win_err_d = 8'd0;
                        end else begin
                            match_d = match_q + 8'd1;
                        end
                    end else begin
                        match_d = 8'd0;
                    end
                end
                LOCKED: begin
                    h_d         = {pred, h_q[3:1]};
                    err_pulse_d = err;
                    if (bit_cnt_q != CNT_MAX) begin
                        bit_cnt_d = bit_cnt_q + 1'b1;
                    end
                    if (err && (err_cnt_q != CNT_MAX)) begin
                        err_cnt_d = err_cnt_q + 1'b1;
                    end
                    if (win_err_sum >= THR) begin
                        // Too many errors in this window: resynchronise from
                        // scratch but keep the measurement counters.
                        state_d     = SEARCH;
                        lock_lost_d = 1'b1;
                        fill_d      = 3'd0;
                        match_d     = 8'd0;
                        h_d         = 4'b0000;
                    end else if (win_cnt_q == WIN_LAST) begin
                        win_cnt_d = 8'd0;
                        win_err_d = 8'd0;
                    end else begin
                        win_cnt_d = win_cnt_q + 8'd1;
                        win_err_d = win_err_sum[7:0];
                    end
                end
                default: state_d = SEARCH;
            endcase
        end

        // Clear takes priority over any increment in the same cycle.
        if (clr_cnt) begin
            err_cnt_d = '0;
            bit_cnt_d = '0;
        end
    end

    always_ff @(posedge clk) begin
        if (res) begin
            state_q     <= SEARCH;
            h_q         <= 4'b0000;
            fill_q      <= 3'd0;
            match_q     <= 8'd0;
            win_cnt_q   <= 8'd0;
            win_err_q   <= 8'd0;
            err_pulse_q <= 1'b0;
            lock_lost_q <= 1'b0;
            err_cnt_q   <= '0;
            bit_cnt_q   <= '0;
        end else begin
            state_q     <= state_d;
            h_q         <= h_d;
            fill_q      <= fill_d;
            match_q     <= match_d;
            win_cnt_q   <= win_cnt_d;
            win_err_q   <= win_err_d;
            err_pulse_q <= err_pulse_d;
            lock_lost_q <= lock_lost_d;
            err_cnt_q   <= err_cnt_d;
            bit_cnt_q   <= bit_cnt_d;
        end
    end

    assign locked    = (state_q == LOCKED);
    assign err_pulse = err_pulse_q;
    assign lock_lost = lock_lost_q;
    assign err_cnt   = err_cnt_q;
    assign bit_cnt   = bit_cnt_q;

endmodule

// File: tb/tb_m_seq_checker.sv
// ---------------------------------------------------------------------------
// tb_m_seq_checker
//   Directed bench for m_seq_checker. A second instance with 3-bit counters
//   shares the stimulus to exercise counter saturation.
// ---------------------------------------------------------------------------
module tb_m_seq_checker;

    logic        clk;
    logic        res;
    logic        din_vld;
    logic        din;
    logic        clr_cnt;
    logic        locked;
    logic        err_pulse;
    logic        lock_lost;
    logic [15:0] err_cnt;
    logic [15:0] bit_cnt;
    logic        s_locked;
    logic        s_err_pulse;
    logic        s_lock_lost;
    logic [2:0]  s_err_cnt;
    logic [2:0]  s_bit_cnt;

    int checks_reg = 0;
    int errors_reg = 0;
    int k          = 0;

    // seq_v[i] = s(i) of 111101011001000
    logic [14:0] seq_v = 15'b000100110101111;

    m_seq_checker dut (
        .clk       (clk),
        .res       (res),
        .din_vld   (din_vld),
        .din       (din),
        .clr_cnt   (clr_cnt),
        .locked    (locked),
        .err_pulse (err_pulse),
        .lock_lost (lock_lost),
        .err_cnt   (err_cnt),
        .bit_cnt   (bit_cnt)
    );

    m_seq_checker #(.CNT_W(3)) dut_sat (
        .clk       (clk),
        .res       (res),
        .din_vld   (din_vld),
        .din       (din),
        .clr_cnt   (clr_cnt),
        .locked    (s_locked),
        .err_pulse (s_err_pulse),
        .lock_lost (s_lock_lost),
        .err_cnt   (s_err_cnt),
        .bit_cnt   (s_bit_cnt)
    );

    initial clk = 1'b0;
    always #5 clk = ~clk;

    task automatic check_val(input string tag, input logic [31:0] got, input logic [31:0] exp);
        checks_reg++;
        if (got !== exp) begin
            errors_reg++;
            $display("FAIL %s got=%0d exp=%0d", tag, got, exp);
        end else begin
            $display("ok   %s = %0d", tag, got);
        end
    endtask

    // Apply one cycle of inputs, then sample 1 time unit after the edge.
    task automatic step(input logic r, input logic v, input logic d, input logic c);
        res     = r;
        din_vld = v;
        din     = d;
        clr_cnt = c;
        @(posedge clk);
        #1;
    endtask

    // Send the next sequence bit, optionally inverted.
    task automatic pbit(input logic inv, input logic clr);
        step(1'b0, 1'b1, seq_v[k] ^ inv, clr);
        k = (k + 1) % 15;
    endtask

    task automatic idle();
        step(1'b0, 1'b0, 1'b0, 1'b0);
    endtask

    logic seen_lock;

    initial begin
        res = 1'b1; din_vld = 1'b0; din = 1'b0; clr_cnt = 1'b0;
        step(1'b1, 1'b0, 1'b0, 1'b0);
        step(1'b1, 1'b0, 1'b0, 1'b0);
        check_val("rst_locked", {31'd0, locked}, 32'd0);
        check_val("rst_err_cnt", {16'd0, err_cnt}, 32'd0);
        check_val("rst_bit_cnt", {16'd0, bit_cnt}, 32'd0);

        // 1: clean stream, lock after 12 bits, then 100 checked bits
        k = 0;
        for (int i = 0; i < 11; i++) pbit(1'b0, 1'b0);
        check_val("t1_not_locked_11", {31'd0, locked}, 32'd0);
        pbit(1'b0, 1'b0);
        check_val("t1_locked_12", {31'd0, locked}, 32'd1);
        for (int i = 0; i < 100; i++) pbit(1'b0, 1'b0);
        check_val("t1_err_cnt", {16'd0, err_cnt}, 32'd0);
        check_val("t1_bit_cnt", {16'd0, bit_cnt}, 32'd100);
        check_val("t1_bit_cnt_sat", {29'd0, s_bit_cnt}, 32'd7);

        // 2: one inverted bit (locked bit 101)
        pbit(1'b1, 1'b0);
        check_val("t2_err_pulse", {31'd0, err_pulse}, 32'd1);
        check_val("t2_err_cnt", {16'd0, err_cnt}, 32'd1);
        check_val("t2_locked", {31'd0, locked}, 32'd1);
        pbit(1'b0, 1'b0);
        check_val("t2_err_pulse_end", {31'd0, err_pulse}, 32'd0);
        for (int i = 0; i < 3; i++) pbit(1'b0, 1'b0);
        check_val("t2_err_cnt_after", {16'd0, err_cnt}, 32'd1);
        check_val("t2_locked_after", {31'd0, locked}, 32'd1);

        // 3: clear counters, then 4 errors in 7 bits of a fresh window
        step(1'b0, 1'b0, 1'b0, 1'b1);
        check_val("t3_clr_err", {16'd0, err_cnt}, 32'd0);
        check_val("t3_clr_bit", {16'd0, bit_cnt}, 32'd0);
        check_val("t3_clr_locked", {31'd0, locked}, 32'd1);
        for (int i = 0; i < 6; i++) pbit((i % 2) == 0, 1'b0);
        check_val("t3_locked_3err", {31'd0, locked}, 32'd1);
        check_val("t3_no_lost_3err", {31'd0, lock_lost}, 32'd0);
        pbit(1'b1, 1'b0);
        check_val("t3_lock_lost", {31'd0, lock_lost}, 32'd1);
        check_val("t3_unlocked", {31'd0, locked}, 32'd0);
        check_val("t3_err_cnt", {16'd0, err_cnt}, 32'd4);
        check_val("t3_bit_cnt", {16'd0, bit_cnt}, 32'd7);
        pbit(1'b0, 1'b0);
        check_val("t3_lock_lost_end", {31'd0, lock_lost}, 32'd0);
        for (int i = 0; i < 10; i++) pbit(1'b0, 1'b0);
        check_val("t3_not_relocked_11", {31'd0, locked}, 32'd0);
        pbit(1'b0, 1'b0);
        check_val("t3_relocked_12", {31'd0, locked}, 32'd1);
        check_val("t3_err_cnt_kept", {16'd0, err_cnt}, 32'd4);
        check_val("t3_bit_cnt_kept", {16'd0, bit_cnt}, 32'd7);

        // 6: reset while locked with err_cnt=5
        pbit(1'b1, 1'b0);
        check_val("t6_err_cnt_5", {16'd0, err_cnt}, 32'd5);
        check_val("t6_sat_err_cnt_5", {29'd0, s_err_cnt}, 32'd5);
        step(1'b1, 1'b0, 1'b0, 1'b0);
        check_val("t6_locked", {31'd0, locked}, 32'd0);
        check_val("t6_err_cnt", {16'd0, err_cnt}, 32'd0);
        check_val("t6_bit_cnt", {16'd0, bit_cnt}, 32'd0);
        check_val("t6_err_pulse", {31'd0, err_pulse}, 32'd0);
        for (int i = 0; i < 11; i++) pbit(1'b0, 1'b0);
        check_val("t6_not_locked_11", {31'd0, locked}, 32'd0);
        pbit(1'b0, 1'b0);
        check_val("t6_locked_12", {31'd0, locked}, 32'd1);

        // 4: constant zero stream never locks
        step(1'b1, 1'b0, 1'b0, 1'b0);
        seen_lock = 1'b0;
        for (int i = 0; i < 60; i++) begin
            step(1'b0, 1'b1, 1'b0, 1'b0);
            seen_lock = seen_lock | locked;
        end
        check_val("t4_never_locked", {31'd0, seen_lock}, 32'd0);
        check_val("t4_err_cnt", {16'd0, err_cnt}, 32'd0);

        // 5: valid every 3rd cycle
        step(1'b1, 1'b0, 1'b0, 1'b0);
        k = 0;
        for (int i = 0; i < 11; i++) begin
            idle();
            idle();
            pbit(1'b0, 1'b0);
        end
        check_val("t5_not_locked_11", {31'd0, locked}, 32'd0);
        idle();
        idle();
        check_val("t5_not_locked_idle", {31'd0, locked}, 32'd0);
        pbit(1'b0, 1'b0);
        check_val("t5_locked_12", {31'd0, locked}, 32'd1);
        idle();
        idle();
        pbit(1'b1, 1'b0);
        check_val("t5_err_cnt_1", {16'd0, err_cnt}, 32'd1);
        check_val("t5_bit_cnt_1", {16'd0, bit_cnt}, 32'd1);
        idle();
        check_val("t5_pulse_idle", {31'd0, err_pulse}, 32'd0);
        idle();
        pbit(1'b1, 1'b1);
        check_val("t5_clr_err_cnt", {16'd0, err_cnt}, 32'd0);
        check_val("t5_clr_bit_cnt", {16'd0, bit_cnt}, 32'd0);
        check_val("t5_clr_err_pulse", {31'd0, err_pulse}, 32'd1);
        check_val("t5_still_locked", {31'd0, locked}, 32'd1);

        $display("CHECKS %0d ERRORS %0d", checks_reg, errors_reg);
        $finish;
    end

endmodule
